lcd_frame_sequencer: RTL and testbench

- Upstream feeder for the character-LCD controller (func/data in, one-cycle valid pulse out).
- Owns a 2x16 character frame buffer written by a host. Keeps the panel in sync by issuing INIT once, then a set-cursor command and 16 data writes per line whenever the buffer is dirty.
- Presents one request at a time on o_func/o_data and advances only on the controller's completion pulse. Includes a watchdog that re-initialises a stalled panel.

---
 rtl/lcd_frame_sequencer.sv | 175 +++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// Request sequencer for a character-LCD controller: mirrors a 2x16 frame buffer onto the
// panel, redrawing whenever it changes and re-initialising the panel if the controller stalls.
module lcd_frame_sequencer #(
    parameter int         CLK_FREQ    = 50_000_000,
    parameter int         TIMEOUT_CYC = 2_000_000,
    parameter logic [7:0] PARK_CMD    = 8'h0C
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_en,
    input  logic [4:0] i_wr_addr,
    input  logic [7:0] i_wr_char,
    input  logic       i_refresh,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_error,
    output logic [1:0] o_func,
    output logic [7:0] o_data,
    input  logic       i_lcd_valid
);

    localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] FUNC_INIT = 2'd0;
    localparam logic [1:0] FUNC_CUR  = 2'd1;
    localparam logic [1:0] FUNC_DATA = 2'd2;
    localparam logic [1:0] FUNC_CMD  = 2'd3;

    // CLK_FREQ is informational only; all panel timing is owned by the controller.
    if (CLK_FREQ <= 0) begin : g_clk_freq_invalid
    end

    typedef enum logic [2:0] {
        S_INIT, S_CUR1, S_LINE1, S_CUR2, S_LINE2, S_PARK
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      col_q, col_d;
    logic            dirty_q, dirty_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [1:0]      func_q, func_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      buf_q [32];
    logic            clr_dirty;
    logic [3:0]      col_inc;

    assign col_inc = col_q + 4'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
        end else if (i_wr_en) begin
            buf_q[i_wr_addr] <= i_wr_char;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        func_d    = func_q;
        data_d    = data_q;
        wdog_d    = wdog_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        clr_dirty = 1'b0;

        if (i_lcd_valid) begin
            wdog_d = '0;
            case (state_q)
                S_INIT: begin
                    state_d = S_CUR1;
                    func_d  = FUNC_CUR;
                    data_d  = 8'h00;
                end
                S_CUR1: begin
                    clr_dirty = 1'b1;
                    col_d     = 4'd0;
                    func_d    = FUNC_DATA;
                    data_d    = buf_q[5'd0];
                    state_d   = S_LINE1;
                end
                S_LINE1: begin
                    if (col_q != 4'd15) begin
                        col_d  = col_inc;
                        func_d = FUNC_DATA;
                        data_d = buf_q[{1'b0, col_inc}];
                    end else begin
                        func_d  = FUNC_CUR;
                        data_d  = 8'h10;
                        state_d = S_CUR2;
                    end
                end
                S_CUR2: begin
                    col_d   = 4'd0;
                    func_d  = FUNC_DATA;
                    data_d  = buf_q[5'd16];
                    state_d = S_LINE2;
                end
                S_LINE2: begin
                    if (col_q != 4'd15) begin
                        col_d  = col_inc;
                        func_d = FUNC_DATA;
                        data_d = buf_q[{1'b1, col_inc}];
                    end else begin
                        done_d = 1'b1;
                        if (dirty_q) begin
                            func_d  = FUNC_CUR;
                            data_d  = 8'h00;
                            state_d = S_CUR1;
                        end else begin
                            func_d  = FUNC_CMD;
                            data_d  = PARK_CMD;
                            state_d = S_PARK;
                        end
                    end
                end
                S_PARK: begin
                    if (dirty_q) begin
                        func_d  = FUNC_CUR;
                        data_d  = 8'h00;
                        state_d = S_CUR1;
                    end else begin
                        func_d = FUNC_CMD;
                        data_d = PARK_CMD;
                    end
                end
                default: state_d = S_INIT;
            endcase
        end else if (wdog_q == WD_LAST) begin
            // Stalled controller: restart the panel from INIT and force a full redraw.
            wdog_d  = '0;
            err_d   = 1'b1;
            state_d = S_INIT;
            func_d  = FUNC_INIT;
            data_d  = 8'h00;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end

        // Any set source wins over the clear taken when a frame starts.
        dirty_d = (dirty_q & ~clr_dirty) | i_wr_en | i_refresh | err_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_INIT;
            col_q   <= 4'd0;
            dirty_q <= 1'b1;
            wdog_q  <= '0;
            func_q  <= FUNC_INIT;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            dirty_q <= dirty_d;
            wdog_q  <= wdog_d;
            func_q  <= func_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_func       = func_q;
    assign o_data       = data_q;
    assign o_frame_done = done_q;
    assign o_error      = err_q;
    assign o_busy       = (state_q != S_PARK);

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer: a controller model answers each request, and a frame-position
// reference model predicts every output cycle by cycle.
module tb_lcd_frame_sequencer;

    localparam int T   = 64;
    localparam int LAT = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_char = '0;
    logic       refresh = 1'b0;
    logic       lcd_valid = 1'b0;
    logic       busy, frame_done, error;
    logic [1:0] func;
    logic [7:0] data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lcd_frame_sequencer #(.TIMEOUT_CYC(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_char(wr_char), .i_refresh(refresh), .o_busy(busy),
        .o_frame_done(frame_done), .o_error(error), .o_func(func), .o_data(data),
        .i_lcd_valid(lcd_valid)
    );

    // Reference model: mode 0 = init, 1 = drawing (pos 0..33 within frame), 2 = parked.
    logic [7:0] m_buf [32];
    bit         m_dirty;
    int         m_mode, m_pos, m_idle;
    logic [1:0] e_func;
    logic [7:0] e_data;
    bit         e_done, e_err;

    int  ctl_cnt, cyc, last_valid_cyc, err_cyc, done_cnt;
    bit  withhold, rand_lat;
    logic [9:0] log_q[$];
    logic [9:0] done_q[$];

    function automatic logic [9:0] req_at(int p);
        if (p == 0)  return {2'd1, 8'h00};
        if (p == 17) return {2'd1, 8'h10};
        if (p < 17)  return {2'd2, m_buf[p-1]};
        return {2'd2, m_buf[p-2]};
    endfunction

    function automatic logic [9:0] get(int idx);
        if (idx < 0 || idx >= log_q.size()) return 10'h3FF;
        return log_q[idx];
    endfunction

    function automatic int find(logic [9:0] v);
        for (int i = 0; i < log_q.size(); i++) if (log_q[i] == v) return i;
        return -100;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_dirty = 1; m_mode = 0; m_pos = 0; m_idle = 0;
        e_func = 2'd0; e_data = 8'h00; e_done = 0; e_err = 0;
    endtask

    task automatic model_edge(input bit v, input bit we, input logic [4:0] wa,
                              input logic [7:0] wc, input bit rf);
        e_done = 0; e_err = 0;
        if (v) begin
            m_idle = 0;
            if (m_mode == 0) begin
                m_mode = 1; m_pos = 0; {e_func, e_data} = req_at(0);
            end else if (m_mode == 1) begin
                if (m_pos == 0) m_dirty = 0;
                m_pos++;
                if (m_pos == 34) begin
                    e_done = 1;
                    if (m_dirty) begin m_pos = 0; {e_func, e_data} = req_at(0); end
                    else begin m_mode = 2; {e_func, e_data} = {2'd3, 8'h0C}; end
                end else begin
                    {e_func, e_data} = req_at(m_pos);
                end
            end else begin
                if (m_dirty) begin m_mode = 1; m_pos = 0; {e_func, e_data} = req_at(0); end
                else {e_func, e_data} = {2'd3, 8'h0C};
            end
        end else begin
            m_idle++;
            if (m_idle == T) begin
                m_idle = 0; e_err = 1; m_mode = 0; m_dirty = 1;
                {e_func, e_data} = {2'd0, 8'h00};
            end
        end
        if (we) begin m_buf[wa] = wc; m_dirty = 1; end
        if (rf) m_dirty = 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        bit v;
        v = !withhold && (ctl_cnt == 0);
        lcd_valid = v;
        if (v) log_q.push_back({func, data});
        model_edge(v, wr_en, wr_addr, wr_char, refresh);
        if (v) begin
            ctl_cnt = rand_lat ? int'($urandom_range(25, 1)) : LAT;
            last_valid_cyc = cyc + 1;
        end else if (ctl_cnt > 0) begin
            ctl_cnt--;
        end
        @(negedge clk);
        cyc++;
        lcd_valid = 1'b0; wr_en = 1'b0; refresh = 1'b0;
        if (frame_done === 1'b1) begin done_cnt++; done_q.push_back({func, data}); end
        if (error === 1'b1) err_cyc = cyc;
        check("func", func, e_func);
        check("data", data, e_data);
        check("busy", busy, (m_mode != 2));
        check("frame_done", frame_done, e_done);
        check("error", error, e_err);
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        tick();
    endtask

    task automatic wait_park(input string tag, input int budget);
        int n;
        n = 0;
        do begin tick(); n++; end while (!(m_mode == 2 && !m_dirty) && n < budget);
        check({tag, "_parked_busy"}, busy, 1'b0);
    endtask

    task automatic wait_pos(input int mode, input int pos, input bit need_valid, input int budget);
        int n;
        n = 0;
        while (!(m_mode == mode && m_pos >= pos && (!need_valid || ctl_cnt == 0)) && n < budget) begin
            tick(); n++;
        end
        check("reach_frame_pos", (n < budget), 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_func"}, func, 2'd0);
        check({tag, "_data"}, data, 8'h00);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_done"}, frame_done, 1'b0);
        check({tag, "_err"}, error, 1'b0);
    endtask

    initial begin
        int i0;
        cyc = 0; done_cnt = 0; withhold = 0; rand_lat = 0; err_cyc = -1; last_valid_cyc = 0;

        // Reset and first full frame with blank buffer
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();
        ctl_cnt = LAT;
        wait_park("first_frame", 3000);
        check("first_log_len", log_q.size(), 35);
        check("first_init", get(0), {2'd0, 8'h00});
        check("first_cur1", get(1), {2'd1, 8'h00});
        check("first_l1c0", get(2), {2'd2, 8'h20});
        check("first_cur2", get(18), {2'd1, 8'h10});
        check("first_l2c15", get(34), {2'd2, 8'h20});
        check("first_done_cnt", done_cnt, 1);
        repeat (60) tick();
        check("park_cmd", get(log_q.size() - 1), {2'd3, 8'h0C});

        // HELLO on line 1
        log_q.delete(); done_q.delete(); done_cnt = 0;
        host_write(5'd0, 8'h48); host_write(5'd1, 8'h45); host_write(5'd2, 8'h4C);
        host_write(5'd3, 8'h4C); host_write(5'd4, 8'h4F);
        wait_park("hello", 3000);
        check("hello_done_cnt", done_cnt, 1);
        i0 = find({2'd1, 8'h00});
        check("hello_H", get(i0 + 1), {2'd2, 8'h48});
        check("hello_E", get(i0 + 2), {2'd2, 8'h45});
        check("hello_L", get(i0 + 3), {2'd2, 8'h4C});
        check("hello_L2", get(i0 + 4), {2'd2, 8'h4C});
        check("hello_O", get(i0 + 5), {2'd2, 8'h4F});
        check("hello_sp5", get(i0 + 6), {2'd2, 8'h20});
        check("hello_sp15", get(i0 + 16), {2'd2, 8'h20});

        // Last cell of line 2
        log_q.delete(); done_cnt = 0;
        host_write(5'd31, 8'h41);
        wait_park("addr31", 3000);
        i0 = find({2'd1, 8'h00});
        check("a31_cur2", get(i0 + 17), {2'd1, 8'h10});
        check("a31_sp0", get(i0 + 18), {2'd2, 8'h20});
        check("a31_sp14", get(i0 + 32), {2'd2, 8'h20});
        check("a31_last", get(i0 + 33), {2'd2, 8'h41});

        // Write during line 2: second frame follows without parking
        done_q.delete(); done_cnt = 0;
        refresh = 1'b1; tick();
        wait_pos(1, 20, 0, 3000);
        host_write(5'd3, 8'h5A);
        wait_park("mid_l2", 4000);
        check("mid_l2_done_cnt", done_cnt, 2);
        check("mid_l2_next_req", done_q[0], {2'd1, 8'h00});
        check("mid_l2_then_park", done_q[1], {2'd3, 8'h0C});

        // Write coincident with the valid that starts a frame
        done_cnt = 0;
        refresh = 1'b1; tick();
        wait_pos(1, 0, 1, 3000);
        host_write(5'd7, 8'h51);
        wait_park("cur1_race", 4000);
        check("cur1_race_done_cnt", done_cnt, 2);

        // Watchdog: controller stalls during line 1
        refresh = 1'b1; tick();
        wait_pos(1, 5, 0, 3000);
        withhold = 1; err_cyc = -1;
        for (int n = 0; n < 3 * T && err_cyc < 0; n++) tick();
        check("wdog_latency", err_cyc - last_valid_cyc, T);
        check("wdog_func", func, 2'd0);
        withhold = 0; ctl_cnt = LAT;
        log_q.delete(); done_cnt = 0;
        wait_park("wdog_recover", 4000);
        check("wdog_done_cnt", done_cnt, 1);
        i0 = find({2'd0, 8'h00});
        check("wdog_reinit_cur", get(i0 + 1), {2'd1, 8'h00});
        check("wdog_buf_kept0", get(i0 + 2), {2'd2, 8'h48});
        check("wdog_buf_kept3", get(i0 + 5), {2'd2, 8'h5A});

        // Random host traffic and controller latency
        rand_lat = 1;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(15, 0) == 0) begin
                wr_en = 1'b1; wr_addr = 5'($urandom_range(31, 0)); wr_char = 8'($urandom_range(255, 0));
            end
            if ($urandom_range(63, 0) == 0) refresh = 1'b1;
            tick();
        end
        wait_park("random", 5000);
        rand_lat = 0;

        // Asynchronous reset mid-frame respaces the buffer
        refresh = 1'b1; tick();
        wait_pos(1, 10, 0, 3000);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        ctl_cnt = LAT; log_q.delete(); done_cnt = 0;
        wait_park("after_reset", 3000);
        check("ar_done_cnt", done_cnt, 1);
        check("ar_init", get(0), {2'd0, 8'h00});
        for (int i = 2; i <= 17; i++) check("ar_line1_space", get(i), {2'd2, 8'h20});
        check("ar_cur2", get(18), {2'd1, 8'h10});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
